// File: rtl/timer_ctrl_if.sv
// Command/status bundle between the keypad front-end, the BCD counter chain
// and the countdown sequencing controller.
interface timer_ctrl_if;
    logic       data_valid;
    logic       start;
    logic       stop;
    logic       clear;
    logic       zero;
    logic       load_n;
    logic       en;
    logic       running;
    logic       done;
    logic [2:0] state;

    modport master (
        output data_valid, start, stop, clear, zero,
        input  load_n, en, running, done, state
    );

    modport slave (
        input  data_valid, start, stop, clear, zero,
        output load_n, en, running, done, state
    );
endinterface

// File: rtl/timer_ctrl.sv
// Countdown timer sequencer: arm/run/pause/done control, tick prescaler and
// load/enable pulses for the cascaded BCD down-counter chain.
module timer_ctrl #(
    parameter int TICK_DIV = 10
) (
    input  logic         clk,
    input  logic         clearn,
    timer_ctrl_if.slave  bus
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_MAX  = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRESC_ZERO = {PW{1'b0}};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b000,
        ST_ARMED = 3'b001,
        ST_RUN   = 3'b010,
        ST_PAUSE = 3'b011,
        ST_DONE  = 3'b100
    } state_t;

    state_t          state_r;
    state_t          state_next_s;
    logic [PW-1:0]   presc_r;
    logic [PW-1:0]   presc_next_s;
    logic            start_q_r;
    logic            stop_q_r;
    logic            load_n_r;
    logic            load_n_next_s;
    logic            en_r;
    logic            en_next_s;
    logic            running_r;
    logic            done_r;
    logic            start_rise_s;
    logic            stop_rise_s;

    // Rising-edge detection of the level commands
    always_comb begin
        start_rise_s = bus.start & ~start_q_r;
        stop_rise_s  = bus.stop  & ~stop_q_r;
    end

    // Next-state, prescaler and pulse generation; a command with no meaning
    // in the current state is ignored and does not mask lower-priority ones
    always_comb begin
        state_next_s  = state_r;
        presc_next_s  = presc_r;
        load_n_next_s = 1'b1;
        en_next_s     = 1'b0;
        if (bus.clear) begin
            state_next_s = ST_IDLE;
            presc_next_s = PRESC_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.data_valid) begin
                        state_next_s  = ST_ARMED;
                        load_n_next_s = 1'b0;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_ARMED: begin
                    if (start_rise_s) begin
                        presc_next_s = PRESC_ZERO;
                        if (bus.zero) begin
                            state_next_s = ST_DONE;
                        end else begin
                            state_next_s = ST_RUN;
                        end
                    end else if (bus.data_valid) begin
                        load_n_next_s = 1'b0;
                    end else begin
                        state_next_s = ST_ARMED;
                    end
                end
                ST_RUN: begin
                    // An exhausted chain ends the run before any further tick
                    if (bus.zero) begin
                        state_next_s = ST_DONE;
                    end else if (stop_rise_s) begin
                        state_next_s = ST_PAUSE;
                    end else if (presc_r == PRESC_MAX) begin
                        presc_next_s = PRESC_ZERO;
                        en_next_s    = 1'b1;
                    end else begin
                        presc_next_s = presc_r + 1'b1;
                    end
                end
                ST_PAUSE: begin
                    if (start_rise_s) begin
                        state_next_s = ST_RUN;
                    end else if (bus.data_valid) begin
                        state_next_s  = ST_ARMED;
                        load_n_next_s = 1'b0;
                    end else begin
                        state_next_s = ST_PAUSE;
                    end
                end
                ST_DONE: begin
                    if (bus.data_valid) begin
                        state_next_s  = ST_ARMED;
                        load_n_next_s = 1'b0;
                    end else begin
                        state_next_s = ST_DONE;
                    end
                end
                default: begin
                    state_next_s = ST_IDLE;
                    presc_next_s = PRESC_ZERO;
                end
            endcase
        end
    end

    // State, prescaler, edge history and registered outputs
    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            state_r   <= ST_IDLE;
            presc_r   <= PRESC_ZERO;
            start_q_r <= 1'b0;
            stop_q_r  <= 1'b0;
            load_n_r  <= 1'b1;
            en_r      <= 1'b0;
            running_r <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            presc_r   <= presc_next_s;
            start_q_r <= bus.start;
            stop_q_r  <= bus.stop;
            load_n_r  <= load_n_next_s;
            en_r      <= en_next_s;
            running_r <= (state_next_s == ST_RUN);
            done_r    <= (state_next_s == ST_DONE);
        end
    end

    assign bus.load_n  = load_n_r;
    assign bus.en      = en_r;
    assign bus.running = running_r;
    assign bus.done    = done_r;
    assign bus.state   = state_r;

endmodule
